// File: rtl/osc_pkg.sv
// Shared types and width helpers for the time-multiplexed resonator oscillator.
package osc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } osc_state_e;

  localparam logic [2:0] MODE_SQR4 = 3'd4;
  localparam int         RES_GUARD = 3;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  function automatic int res_w(input int w);
    return w + RES_GUARD;
  endfunction

endpackage

// File: rtl/osc_resonator_core.sv
// Shared datapath: r = ((a*y1) >>> FRAC) - y2 with optional clamp, plus zero-crossing detect on y1.
module osc_resonator_core
  import osc_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = 29,
  parameter int ZCB  = 10,
  parameter int ZCB4 = 9,
  parameter int SAT  = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] y1,
  input  logic [W-1:0] y2,
  input  logic [2:0]   Mode,
  output logic [W-1:0] r,
  output logic         zc
);
  localparam int PW = prod_w(W);
  localparam int RW = res_w(W);

  logic signed [PW-1:0] prod;
  logic signed [RW-1:0] p;
  logic signed [RW-1:0] diff;
  logic                 zc_n;
  logic                 zc_4;

  // With |a| < 4 the shifted product always fits in W+3 bits, so truncation is lossless.
  assign prod = $signed(a) * $signed(y1);
  assign p    = RW'(prod >>> FRAC);
  assign diff = p - $signed({{RES_GUARD{y2[W-1]}}, y2});

  always_comb begin
    r = diff[W-1:0];
    if (SAT != 0) begin
      if (diff[RW-1] && !(&diff[RW-2:W-1]))
        r = {1'b1, {(W-1){1'b0}}};
      else if (!diff[RW-1] && (|diff[RW-2:W-1]))
        r = {1'b0, {(W-1){1'b1}}};
    end
  end

  assign zc_n = (&y1[W-1 -: ZCB])  | ~(|y1[W-1 -: ZCB]);
  assign zc_4 = (&y1[W-1 -: ZCB4]) | ~(|y1[W-1 -: ZCB4]);
  assign zc   = (Mode == MODE_SQR4) ? zc_4 : zc_n;

endmodule

// File: rtl/multi_resonator_osc.sv
// N-channel recursive sine generator: one shared core swept over per-channel state on each tick.
module multi_resonator_osc
  import osc_pkg::*;
#(
  parameter int           NCH   = 4,
  parameter int           W     = 32,
  parameter int           FRAC  = 29,
  parameter int           ZCB   = 10,
  parameter int           ZCB4  = 9,
  parameter logic [W-1:0] SEED2 = 'hAB,
  parameter int           SAT   = 1,
  localparam int          CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           Fg_clk,
  input  logic           Reset,
  input  logic [2:0]     Mode,
  input  logic [NCH-1:0] ch_en,
  input  logic           tick,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_ch,
  input  logic           cfg_defer,
  input  logic [W-1:0]   cfg_init1,
  input  logic [W-1:0]   cfg_init2,
  output logic           out_valid,
  output logic [CW-1:0]  out_ch,
  output logic [W-1:0]   out_data,
  output logic           sweep_done,
  output logic           overrun
);
  osc_state_e state, state_nx;
  logic [CW-1:0]         ch;
  logic [NCH-1:0][W-1:0] y1, y2, a, pend1, pend2;
  logic [NCH-1:0]        waiting;
  logic [W-1:0]          r_nx, r_q, y1_new;
  logic                  zc_nx, zc_q, upd, cfg_acc;

  assign cfg_ready = (state == ST_IDLE);
  assign cfg_acc   = cfg_valid && cfg_ready;

  osc_resonator_core #(.W(W), .FRAC(FRAC), .ZCB(ZCB), .ZCB4(ZCB4), .SAT(SAT)) u_core (
    .a(a[ch]), .y1(y1[ch]), .y2(y2[ch]), .Mode(Mode), .r(r_nx), .zc(zc_nx)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (tick) state_nx = ST_CALC;
      ST_CALC:  state_nx = ST_WRITE;
      ST_WRITE: state_nx = (ch == CW'(NCH-1)) ? ST_DONE : ST_CALC;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // A pending reload only lands on a zero crossing, keeping the output phase-continuous.
  always_comb begin
    upd    = zc_q && waiting[ch] && ch_en[ch];
    y1_new = r_q;
    if (upd) y1_new = y2[ch][W-1] ? pend1[ch] : -pend1[ch];
  end

  always_ff @(posedge Fg_clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      ch         <= '0;
      y1         <= '0;
      y2         <= '0;
      a          <= '0;
      pend1      <= '0;
      pend2      <= '0;
      waiting    <= '0;
      r_q        <= '0;
      zc_q       <= 1'b0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_data   <= '0;
      sweep_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nx;
      out_valid  <= 1'b0;
      sweep_done <= 1'b0;
      if (tick && state != ST_IDLE) overrun <= 1'b1;
      if (cfg_acc) begin
        if (cfg_defer) begin
          pend1[cfg_ch]   <= cfg_init1;
          pend2[cfg_ch]   <= cfg_init2;
          waiting[cfg_ch] <= 1'b1;
        end else begin
          y1[cfg_ch]      <= y2[cfg_ch][W-1] ? cfg_init1 : -cfg_init1;
          y2[cfg_ch]      <= SEED2;
          a[cfg_ch]       <= cfg_init2;
          waiting[cfg_ch] <= 1'b0;
        end
      end
      unique case (state)
        ST_IDLE: ch <= '0;
        ST_CALC: begin
          r_q  <= r_nx;
          zc_q <= zc_nx;
        end
        ST_WRITE: begin
          if (ch_en[ch]) begin
            if (upd) begin
              y2[ch]      <= SEED2;
              a[ch]       <= pend2[ch];
              waiting[ch] <= 1'b0;
            end else begin
              y2[ch] <= y1[ch];
            end
            y1[ch]    <= y1_new;
            out_valid <= 1'b1;
            out_ch    <= ch;
            out_data  <= y1_new;
          end
          ch <= ch + 1'b1;
        end
        ST_DONE: sweep_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
